// File: rtl/program_end_monitor.sv
// rtl/program_end_monitor.sv - detects the program terminator, drains the pipeline, and keeps run statistics
//
// Purpose:
//   Watches the IF stage for the all-zero terminator instruction. Once the
//   terminator is accepted, the block waits DRAIN_CYCLES so that older
//   instructions can retire, then raises end_program. A taken-branch flush
//   during the drain cancels it, because the terminator was on a wrong path.
//   An optional cycle-count timeout (MAX_CYCLES) forces completion.
//   Event counters run while the program is live and freeze on completion.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   if_valid      in   IF stage holds a real fetched instruction
//   if_pc[63:0]   in   PC of the IF-stage instruction
//   if_instr[31:0] in  IF-stage instruction word
//   stall         in   IF/ID held this cycle
//   flush         in   IF/ID flushed this cycle
//   wb_valid      in   an instruction retires in WB this cycle
//   mem_read      in   MEM-stage load active
//   mem_write     in   MEM-stage store active
//   end_program   out  program complete, pipeline drained
//   timeout       out  completion was forced by MAX_CYCLES
//   pc_at_end     out  PC of the accepted terminator (or of the timeout cycle)
//   cycle_count, retired_count, stall_count, load_count, store_count
//                 out  32-bit saturating event counters
//   state[1:0]    out  FSM state (RUN=0, DRAIN=1, DONE=2)

module program_end_monitor #(
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_CYCLES   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [63:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        end_program,
    output logic        timeout,
    output logic [63:0] pc_at_end,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count,
    output logic [31:0] stall_count,
    output logic [31:0] load_count,
    output logic [31:0] store_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0]  LP_DRAIN  = 4'(DRAIN_CYCLES);
    localparam logic [31:0] LP_MAX_M1 = 32'(MAX_CYCLES - 1);
    localparam bit          LP_TO_EN  = (MAX_CYCLES != 0);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_drain_cnt;
    logic [3:0]  w_next_drain_cnt;
    logic        r_end_program;
    logic        r_timeout;
    logic [63:0] r_pc_at_end;
    logic [31:0] r_cycle_count;
    logic [31:0] r_retired_count;
    logic [31:0] r_stall_count;
    logic [31:0] r_load_count;
    logic [31:0] r_store_count;

    logic        w_terminator;
    logic        w_counting;
    logic        w_timeout_hit;
    logic        w_latch_pc;
    logic        w_set_timeout;

    // A held or flushed fetch is not a real terminator, even if the word is zero.
    assign w_terminator  = if_valid && !stall && !flush && (if_instr == 32'h0000_0000);
    assign w_counting    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_timeout_hit = LP_TO_EN && w_counting && (r_cycle_count == LP_MAX_M1);

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        if (en && (value != 32'hFFFF_FFFF)) begin
            return value + 32'd1;
        end
        return value;
    endfunction

    always_comb begin
        w_next_state     = r_state;
        w_next_drain_cnt = r_drain_cnt;
        w_latch_pc       = 1'b0;
        w_set_timeout    = 1'b0;
        case (r_state)
            ST_RUN: begin
                // Timeout wins over a terminator seen on the same edge.
                if (w_timeout_hit) begin
                    w_next_state  = ST_DONE;
                    w_latch_pc    = 1'b1;
                    w_set_timeout = 1'b1;
                end else if (w_terminator) begin
                    w_next_state     = ST_DRAIN;
                    w_latch_pc       = 1'b1;
                    w_next_drain_cnt = LP_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Further terminators are ignored here: no relatch, no reload.
                if (w_timeout_hit) begin
                    w_next_state  = ST_DONE;
                    w_latch_pc    = 1'b1;
                    w_set_timeout = 1'b1;
                end else if (flush) begin
                    w_next_state     = ST_RUN;
                    w_next_drain_cnt = 4'd0;
                end else begin
                    w_next_drain_cnt = r_drain_cnt - 4'd1;
                    if (r_drain_cnt == 4'd1) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state     = ST_RUN;
                w_next_drain_cnt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_drain_cnt   <= 4'd0;
            r_end_program <= 1'b0;
            r_timeout     <= 1'b0;
            r_pc_at_end   <= 64'd0;
        end else begin
            r_state       <= w_next_state;
            r_drain_cnt   <= w_next_drain_cnt;
            r_end_program <= (w_next_state == ST_DONE);
            r_timeout     <= r_timeout | w_set_timeout;
            if (w_latch_pc) begin
                r_pc_at_end <= if_pc;
            end
        end
    end

    // Counters follow the current state, so the edge that enters DONE still counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_count   <= 32'd0;
            r_retired_count <= 32'd0;
            r_stall_count   <= 32'd0;
            r_load_count    <= 32'd0;
            r_store_count   <= 32'd0;
        end else if (w_counting) begin
            r_cycle_count   <= sat_inc(r_cycle_count, 1'b1);
            r_retired_count <= sat_inc(r_retired_count, wb_valid);
            r_stall_count   <= sat_inc(r_stall_count, stall);
            r_load_count    <= sat_inc(r_load_count, mem_read);
            r_store_count   <= sat_inc(r_store_count, mem_write);
        end
    end

    assign end_program   = r_end_program;
    assign timeout       = r_timeout;
    assign pc_at_end     = r_pc_at_end;
    assign cycle_count   = r_cycle_count;
    assign retired_count = r_retired_count;
    assign stall_count   = r_stall_count;
    assign load_count    = r_load_count;
    assign store_count   = r_store_count;
    assign state         = r_state;

endmodule

// File: tb/tb_program_end_monitor.sv
// tb/tb_program_end_monitor.sv - scoreboard bench for program_end_monitor

module tb_program_end_monitor;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] cyc;
        logic [31:0] ret;
        logic [31:0] stl;
        logic [31:0] ld;
        logic [31:0] st;
        logic        to;
        int          edge_n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_rst_main;
    logic        r_rst_to;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        stall;
    logic        flush;
    logic        wb_valid;
    logic        mem_read;
    logic        mem_write;

    logic        m_end, m_to;
    logic [63:0] m_pc;
    logic [31:0] m_cyc, m_ret, m_stl, m_ld, m_st;
    logic [1:0]  m_state;

    logic        t_end, t_to;
    logic [63:0] t_pc;
    logic [31:0] t_cyc, t_ret, t_stl, t_ld, t_st;
    logic [1:0]  t_state;

    program_end_monitor u_dut (
        .clk(clk), .reset(r_rst_main), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .stall(stall), .flush(flush), .wb_valid(wb_valid),
        .mem_read(mem_read), .mem_write(mem_write), .end_program(m_end),
        .timeout(m_to), .pc_at_end(m_pc), .cycle_count(m_cyc),
        .retired_count(m_ret), .stall_count(m_stl), .load_count(m_ld),
        .store_count(m_st), .state(m_state)
    );

    program_end_monitor #(.DRAIN_CYCLES(4), .MAX_CYCLES(8)) u_dut_to (
        .clk(clk), .reset(r_rst_to), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .stall(stall), .flush(flush), .wb_valid(wb_valid),
        .mem_read(mem_read), .mem_write(mem_write), .end_program(t_end),
        .timeout(t_to), .pc_at_end(t_pc), .cycle_count(t_cyc),
        .retired_count(t_ret), .stall_count(t_stl), .load_count(t_ld),
        .store_count(t_st), .state(t_state)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q_main[$];
    exp_t q_to[$];
    int   edge_main;
    int   edge_to;
    logic prev_m = 1'b0;
    logic prev_t = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_rec(input string tag, input exp_t e, input int edge_n,
                               input logic [63:0] pc, input logic [31:0] cyc,
                               input logic [31:0] ret, input logic [31:0] stl,
                               input logic [31:0] ld, input logic [31:0] st,
                               input logic to, input logic [1:0] stv);
        chk({tag, "_edge"}, 64'(edge_n), 64'(e.edge_n));
        chk({tag, "_pc_at_end"}, pc, e.pc);
        chk({tag, "_cycle_count"}, 64'(cyc), 64'(e.cyc));
        chk({tag, "_retired_count"}, 64'(ret), 64'(e.ret));
        chk({tag, "_stall_count"}, 64'(stl), 64'(e.stl));
        chk({tag, "_load_count"}, 64'(ld), 64'(e.ld));
        chk({tag, "_store_count"}, 64'(st), 64'(e.st));
        chk({tag, "_timeout"}, 64'(to), 64'(e.to));
        chk({tag, "_state"}, 64'(stv), 64'd2);
    endtask

    always @(posedge clk or negedge r_rst_main) begin
        if (!r_rst_main) edge_main <= 0;
        else             edge_main <= edge_main + 1;
    end

    always @(posedge clk or negedge r_rst_to) begin
        if (!r_rst_to) edge_to <= 0;
        else           edge_to <= edge_to + 1;
    end

    // Monitors: pop an expected completion whenever end_program rises.
    always @(negedge clk) begin : mon_main
        exp_t e;
        if (m_end && !prev_m) begin
            if (q_main.size() == 0) begin
                chk("main_unexpected_end", 64'(m_end), 64'd0);
            end else begin
                e = q_main.pop_front();
                compare_rec("main", e, edge_main, m_pc, m_cyc, m_ret, m_stl, m_ld, m_st, m_to, m_state);
            end
        end
        prev_m <= m_end;
    end

    always @(negedge clk) begin : mon_to
        exp_t e;
        if (t_end && !prev_t) begin
            if (q_to.size() == 0) begin
                chk("to_unexpected_end", 64'(t_end), 64'd0);
            end else begin
                e = q_to.pop_front();
                compare_rec("to", e, edge_to, t_pc, t_cyc, t_ret, t_stl, t_ld, t_st, t_to, t_state);
            end
        end
        prev_t <= t_end;
    end

    function automatic exp_t mk(input logic [63:0] pc, input int cyc, input int ret,
                                input int stl, input int ld, input int st,
                                input logic to, input int edge_n);
        exp_t e;
        e.pc = pc; e.cyc = 32'(cyc); e.ret = 32'(ret); e.stl = 32'(stl);
        e.ld = 32'(ld); e.st = 32'(st); e.to = to; e.edge_n = edge_n;
        return e;
    endfunction

    // One rising edge consumes the given inputs; returns just after the falling edge.
    task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                        input logic st, input logic fl, input logic wb,
                        input logic rd, input logic wr);
        if_valid = v; if_pc = pc; if_instr = instr; stall = st; flush = fl;
        wb_valid = wb; mem_read = rd; mem_write = wr;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 64'd0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_main(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q_main.size() == 0) break;
            idle();
        end
        chk("main_done_wait", 64'(q_main.size()), 64'd0);
        q_main.delete();
    endtask

    task automatic wait_to(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q_to.size() == 0) break;
            idle();
        end
        chk("to_done_wait", 64'(q_to.size()), 64'd0);
        q_to.delete();
    endtask

    task automatic reset_main();
        r_rst_main = 1'b0;
        #1;
        @(negedge clk);
        #1;
        r_rst_main = 1'b1;
    endtask

    initial begin
        r_rst_main = 1'b0; r_rst_to = 1'b0;
        if_valid = 1'b0; if_pc = 64'd0; if_instr = 32'h13; stall = 1'b0;
        flush = 1'b0; wb_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #3;
        chk("rst_state", 64'(m_state), 64'd0);
        chk("rst_end_program", 64'(m_end), 64'd0);
        chk("rst_timeout", 64'(m_to), 64'd0);
        chk("rst_pc_at_end", m_pc, 64'd0);
        chk("rst_cycle_count", 64'(m_cyc), 64'd0);
        chk("rst_retired_count", 64'(m_ret), 64'd0);
        chk("rst_stall_count", 64'(m_stl), 64'd0);
        chk("rst_load_count", 64'(m_ld), 64'd0);
        chk("rst_store_count", 64'(m_st), 64'd0);
        @(negedge clk);
        #1;
        r_rst_main = 1'b1;

        // Four retiring instructions, then terminator at 0x10; DONE after edge 9.
        q_main.push_back(mk(64'h10, 9, 4, 0, 0, 0, 1'b0, 9));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 64'(4 * i), 32'h0000_0013, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 64'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_main(20);

        // Wrong-path terminator cancelled by flush, then a real one at 0x20.
        reset_main();
        q_main.push_back(mk(64'h20, 8, 0, 0, 0, 0, 1'b0, 8));
        step(1'b1, 64'h18, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_drain_entered", 64'(m_state), 64'd1);
        idle();
        step(1'b0, 64'h1C, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_back_to_run", 64'(m_state), 64'd0);
        chk("flush_no_end", 64'(m_end), 64'd0);
        step(1'b1, 64'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_main(20);

        // Terminator held by stall for three cycles; DRAIN only after release.
        reset_main();
        q_main.push_back(mk(64'h30, 8, 0, 3, 0, 0, 1'b0, 8));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 64'h30, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("stall_still_run", 64'(m_state), 64'd0);
        step(1'b1, 64'h30, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_drain_after_release", 64'(m_state), 64'd1);
        wait_main(20);

        // Asynchronous reset mid-DRAIN, checked before any clock edge.
        reset_main();
        step(1'b1, 64'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("midrst_in_drain", 64'(m_state), 64'd1);
        #2;
        r_rst_main = 1'b0;
        #1;
        chk("midrst_state", 64'(m_state), 64'd0);
        chk("midrst_end_program", 64'(m_end), 64'd0);
        chk("midrst_pc_at_end", m_pc, 64'd0);
        chk("midrst_cycle_count", 64'(m_cyc), 64'd0);
        @(negedge clk);
        #1;
        r_rst_main = 1'b1;

        // Loads and stores together, then freeze after DONE with toggling inputs.
        q_main.push_back(mk(64'h58, 7, 1, 0, 2, 2, 1'b0, 7));
        step(1'b1, 64'h50, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 64'h54, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 64'h58, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_main(20);
        step(1'b1, 64'h60, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 64'h64, 32'h0000_0013, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 64'h68, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("frozen_cycle_count", 64'(m_cyc), 64'd7);
        chk("frozen_retired_count", 64'(m_ret), 64'd1);
        chk("frozen_stall_count", 64'(m_stl), 64'd0);
        chk("frozen_load_count", 64'(m_ld), 64'd2);
        chk("frozen_store_count", 64'(m_st), 64'd2);
        chk("frozen_pc_at_end", m_pc, 64'h58);
        chk("frozen_state", 64'(m_state), 64'd2);
        chk("frozen_end_program", 64'(m_end), 64'd1);

        // MAX_CYCLES=8: timeout on edge 8 overrides a terminator on that same edge.
        r_rst_main = 1'b0;
        r_rst_to   = 1'b1;
        q_to.push_back(mk(64'h11C, 8, 8, 0, 0, 0, 1'b1, 8));
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 64'h100 + 64'(4 * i), 32'h0000_0013, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 64'h11C, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_to(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
